// File: rtl/inst_queue_pkg.sv
// Instruction-queue entry layout shared by decode, the queue and issue.
// WIDTH_UOP normally comes from uop.vh; a default keeps standalone builds complete.
`ifndef WIDTH_UOP
`define WIDTH_UOP 8
`endif

package inst_queue_pkg;
  localparam int IQ_UOP_W    = `WIDTH_UOP;
  localparam int IQ_UOP_OFF  = 0;
  localparam int IQ_RJ_OFF   = IQ_UOP_OFF + IQ_UOP_W;
  localparam int IQ_RK_OFF   = IQ_RJ_OFF + 5;
  localparam int IQ_RD_OFF   = IQ_RK_OFF + 5;
  localparam int IQ_IMM_OFF  = IQ_RD_OFF + 5;
  localparam int IQ_EXC_OFF  = IQ_IMM_OFF + 32;
  localparam int IQ_BADV_OFF = IQ_EXC_OFF + 7;
  localparam int IQ_PC_OFF   = IQ_BADV_OFF + 32;
  localparam int IQ_PCN_OFF  = IQ_PC_OFF + 32;
  localparam int IQ_ENTRY_W  = IQ_PCN_OFF + 32;

  typedef struct packed {
    logic [31:0]         pc_next;
    logic [31:0]         pc;
    logic [31:0]         badv;
    logic [6:0]          exception;
    logic [31:0]         imm;
    logic [4:0]          rd;
    logic [4:0]          rk;
    logic [4:0]          rj;
    logic [IQ_UOP_W-1:0] uop;
  } iq_entry_t;

  // Issue decodes uop 0 / exception 0 as a nop; pc_next=4 keeps the bubble's fall-through sane.
  localparam logic [IQ_ENTRY_W-1:0] IQ_BUBBLE = {32'd4, {(IQ_ENTRY_W-32){1'b0}}};

  function automatic logic [1:0] iq_pop_req(input logic [1:0] num_read);
    case (num_read)
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/iq_entry_ram.sv
// DEPTH x IQ_ENTRY_W register array: two write ports (tail, tail+1), two async reads (head, head+1).
module iq_entry_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic [1:0]                    we,
  input  logic [1:0][PTR_W-1:0]         waddr,
  input  logic [1:0][IQ_ENTRY_W-1:0]    wdata,
  input  logic [1:0][PTR_W-1:0]         raddr,
  output logic [1:0][IQ_ENTRY_W-1:0]    rdata
);
  logic [IQ_ENTRY_W-1:0] mem [DEPTH];

  // Write addresses are always distinct (tail vs tail+1), so port order is irrelevant.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (we[p]) mem[waddr[p]] <= wdata[p];
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    assign rdata[p] = mem[raddr[p]];
  end
endmodule

// File: rtl/inst_queue.sv
// Two-wide circular instruction queue between decode and in-order issue.
// Define IQ_PERF_CNT_EN to add saturating full/empty cycle counters.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic [1:0]          in_valid,
  output logic                in_ready,
  input  logic [IQ_UOP_W-1:0] in_uop0,
  input  logic [IQ_UOP_W-1:0] in_uop1,
  input  logic [4:0]          in_rd0,
  input  logic [4:0]          in_rj0,
  input  logic [4:0]          in_rk0,
  input  logic [4:0]          in_rd1,
  input  logic [4:0]          in_rj1,
  input  logic [4:0]          in_rk1,
  input  logic [31:0]         in_imm0,
  input  logic [31:0]         in_imm1,
  input  logic [6:0]          in_exception0,
  input  logic [6:0]          in_exception1,
  input  logic [31:0]         in_badv0,
  input  logic [31:0]         in_badv1,
  input  logic [31:0]         in_pc0,
  input  logic [31:0]         in_pc1,
  input  logic [31:0]         in_pc_next0,
  input  logic [31:0]         in_pc_next1,
  input  logic [1:0]          num_read,
  output logic [IQ_UOP_W-1:0] out_uop0,
  output logic [IQ_UOP_W-1:0] out_uop1,
  output logic [4:0]          out_rd0,
  output logic [4:0]          out_rj0,
  output logic [4:0]          out_rk0,
  output logic [4:0]          out_rd1,
  output logic [4:0]          out_rj1,
  output logic [4:0]          out_rk1,
  output logic [31:0]         out_imm0,
  output logic [31:0]         out_imm1,
  output logic [6:0]          out_exception0,
  output logic [6:0]          out_exception1,
  output logic [31:0]         out_badv0,
  output logic [31:0]         out_badv1,
  output logic [31:0]         out_pc0,
  output logic [31:0]         out_pc1,
  output logic [31:0]         out_pc_next0,
  output logic [31:0]         out_pc_next1,
  output logic [PTR_W:0]      count
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0]         perf_full_cycles,
  output logic [31:0]         perf_empty_cycles
`endif
);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]             head, tail;
  logic [1:0]                   push_n, pop_n, req;
  iq_entry_t [1:0]              lane, slot;
  logic [1:0]                   we;
  logic [1:0][PTR_W-1:0]        waddr, raddr;
  logic [1:0][IQ_ENTRY_W-1:0]   wdata, rdata;

  assign lane[0] = '{pc_next: in_pc_next0, pc: in_pc0, badv: in_badv0, exception: in_exception0,
                     imm: in_imm0, rd: in_rd0, rk: in_rk0, rj: in_rj0, uop: in_uop0};
  assign lane[1] = '{pc_next: in_pc_next1, pc: in_pc1, badv: in_badv1, exception: in_exception1,
                     imm: in_imm1, rd: in_rd1, rk: in_rk1, rj: in_rj1, uop: in_uop1};

  // Registered count only, so in_ready never depends on same-cycle issue.
  assign in_ready = (count <= CNT_W'(DEPTH - 2));
  assign push_n   = in_ready ? (2'(in_valid[0]) + 2'(in_valid[1])) : 2'd0;
  assign req      = iq_pop_req(num_read);
  assign pop_n    = (CNT_W'(req) > count) ? count[1:0] : req;

  // Compaction: a lone lane1 instruction lands at tail through port 0.
  assign wdata[0] = in_valid[0] ? lane[0] : lane[1];
  assign wdata[1] = lane[1];
  assign waddr[0] = tail;
  assign waddr[1] = tail + PTR_W'(1);
  assign we       = {push_n == 2'd2, push_n != 2'd0} & {2{~flush}};
  assign raddr[0] = head;
  assign raddr[1] = head + PTR_W'(1);

  iq_entry_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_n);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  assign slot[0] = (count != '0)          ? rdata[0] : IQ_BUBBLE;
  assign slot[1] = (count >= CNT_W'(2))   ? rdata[1] : IQ_BUBBLE;

  assign out_uop0       = slot[0].uop;
  assign out_uop1       = slot[1].uop;
  assign out_rd0        = slot[0].rd;
  assign out_rj0        = slot[0].rj;
  assign out_rk0        = slot[0].rk;
  assign out_rd1        = slot[1].rd;
  assign out_rj1        = slot[1].rj;
  assign out_rk1        = slot[1].rk;
  assign out_imm0       = slot[0].imm;
  assign out_imm1       = slot[1].imm;
  assign out_exception0 = slot[0].exception;
  assign out_exception1 = slot[1].exception;
  assign out_badv0      = slot[0].badv;
  assign out_badv1      = slot[1].badv;
  assign out_pc0        = slot[0].pc;
  assign out_pc1        = slot[1].pc;
  assign out_pc_next0   = slot[0].pc_next;
  assign out_pc_next1   = slot[1].pc_next;

`ifdef IQ_PERF_CNT_EN
  // Survive flush on purpose: they measure the whole run, not one redirect window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if ((in_valid != 2'b00) && !in_ready && !(&perf_full_cycles))
        perf_full_cycles <= perf_full_cycles + 32'd1;
      if ((count == '0) && !(&perf_empty_cycles))
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rstn && !flush) begin
      assert (num_read != 2'b10)
        else $warning("inst_queue: num_read=2'b10 is illegal, treated as no pop");
      assert (count <= CNT_W'(DEPTH))
        else $error("inst_queue: occupancy above DEPTH");
    end
  end
`endif
endmodule
